// File: rtl/boot_ctrl_if.sv
// Load-stream handshake between an image source and boot_ctrl.
interface boot_ctrl_if;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_ready;

    // Image source side
    modport master (
        output ld_valid,
        output ld_data,
        output ld_last,
        input  ld_ready
    );

    // boot_ctrl side
    modport slave (
        input  ld_valid,
        input  ld_data,
        input  ld_last,
        output ld_ready
    );
endinterface

// File: rtl/boot_ctrl.sv
// Boot/reload sequencer: holds the core in reset, streams an image into
// instruction memory, then releases the core after a fixed hold period.
module boot_ctrl #(
    parameter int unsigned IMEM_WORDS = 256,
    parameter int unsigned RST_HOLD   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    boot_ctrl_if.slave                    ld,
    input  logic                          reload,
    output logic                          imem_we,
    output logic [9:0]                    imem_waddr,
    output logic [31:0]                   imem_wdata,
    output logic                          core_rst,
    output logic                          boot_done,
    output logic                          boot_err,
    output logic [$clog2(IMEM_WORDS):0]   word_count
);

    localparam int unsigned CW = $clog2(IMEM_WORDS) + 1;
    localparam int unsigned AW = 10;
    localparam int unsigned HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [HW-1:0] hold_cnt;
    logic          hs;
    logic          at_top;
    logic          enter_load;

    // Ready depends on state only, and is masked while reset is applied
    assign ld.ld_ready = (state == S_LOAD) && !rst;
    assign hs          = ld.ld_valid && ld.ld_ready;
    assign at_top      = (word_count == CW'(IMEM_WORDS - 1));
    assign enter_load  = (state != S_LOAD) && (state_nxt == S_LOAD);

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD: begin
                if (hs) begin
                    if (ld.ld_last) begin
                        state_nxt = S_HOLD;
                    end else if (at_top) begin
                        state_nxt = S_ERR;
                    end
                end
            end
            S_HOLD: begin
                if (hold_cnt == '0) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (reload) begin
                    state_nxt = S_LOAD;
                end
            end
            S_ERR: begin
                if (reload) begin
                    state_nxt = S_LOAD;
                end
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Release delay counter, armed on entry to HOLD
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if ((state != S_HOLD) && (state_nxt == S_HOLD)) begin
            hold_cnt <= HW'(RST_HOLD - 1);
        end else if ((state == S_HOLD) && (hold_cnt != '0)) begin
            hold_cnt <= hold_cnt - HW'(1);
        end
    end

    // Registered memory write port, word counter and core status
    always_ff @(posedge clk) begin
        if (rst) begin
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            word_count <= '0;
            core_rst   <= 1'b1;
            boot_done  <= 1'b0;
            boot_err   <= 1'b0;
        end else begin
            imem_we <= hs;
            if (hs) begin
                imem_waddr <= AW'({word_count, 2'b00});
                imem_wdata <= ld.ld_data;
            end
            if (enter_load) begin
                word_count <= '0;
            end else if (hs && (word_count != CW'(IMEM_WORDS))) begin
                word_count <= word_count + CW'(1);
            end
            core_rst  <= (state_nxt != S_RUN);
            boot_done <= (state_nxt == S_RUN);
            boot_err  <= (state_nxt == S_ERR);
        end
    end

endmodule

// File: tb/tb_boot_ctrl.sv
// Directed bench for boot_ctrl: a default-size instance (a) and a
// 4-word instance (b) for the overflow boundary.
module tb_boot_ctrl;

    logic        clk = 1'b0;
    logic        rst_a, rst_b, reload_a, reload_b;
    logic        we_a, we_b;
    logic [9:0]  waddr_a, waddr_b;
    logic [31:0] wdata_a, wdata_b;
    logic        crst_a, crst_b, done_a, done_b, err_a, err_b;
    logic [8:0]  cnt_a;
    logic [2:0]  cnt_b;

    int total = 0;
    int bad   = 0;

    logic [31:0] img [3] = '{32'h00500093, 32'h00108133, 32'h0000006F};
    int          gaps [3] = '{2, 0, 3};

    boot_ctrl_if ia ();
    boot_ctrl_if ib ();

    boot_ctrl #(.IMEM_WORDS(256), .RST_HOLD(2)) u_a (
        .clk(clk), .rst(rst_a), .ld(ia.slave), .reload(reload_a),
        .imem_we(we_a), .imem_waddr(waddr_a), .imem_wdata(wdata_a),
        .core_rst(crst_a), .boot_done(done_a), .boot_err(err_a),
        .word_count(cnt_a)
    );

    boot_ctrl #(.IMEM_WORDS(4), .RST_HOLD(2)) u_b (
        .clk(clk), .rst(rst_b), .ld(ib.slave), .reload(reload_b),
        .imem_we(we_b), .imem_waddr(waddr_b), .imem_wdata(wdata_b),
        .core_rst(crst_b), .boot_done(done_b), .boot_err(err_b),
        .word_count(cnt_b)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_a = 1'b1; rst_b = 1'b1;
        ia.ld_valid = 1'b1; ia.ld_data = 32'hDEADBEEF;
        tick; tick;
        total++; if (crst_a !== 1'b1) begin bad++; $display("FAIL rst_core_rst got=%b want=1", crst_a); end
        total++; if (we_a !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", we_a); end
        total++; if (waddr_a !== 10'h000) begin bad++; $display("FAIL rst_waddr got=%h want=000", waddr_a); end
        total++; if (wdata_a !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h want=0", wdata_a); end
        total++; if (done_a !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done_a); end
        total++; if (err_a !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err_a); end
        total++; if (cnt_a !== 9'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", cnt_a); end
        total++; if (ia.ld_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", ia.ld_ready); end
        total++; if (ib.ld_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_b got=%b want=0", ib.ld_ready); end
        ia.ld_valid = 1'b0;
        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        total++; if (ia.ld_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b want=1", ia.ld_ready); end
        total++; if (ib.ld_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready_b got=%b want=1", ib.ld_ready); end
    endtask

    task automatic test_stream;
        for (int i = 0; i < 3; i++) begin
            ia.ld_valid = 1'b1; ia.ld_data = img[i]; ia.ld_last = (i == 2);
            tick;
            total++; if (we_a !== 1'b1) begin bad++; $display("FAIL stream_we%0d got=%b want=1", i, we_a); end
            total++; if (waddr_a !== 10'(i * 4)) begin bad++; $display("FAIL stream_addr%0d got=%h want=%h", i, waddr_a, 10'(i * 4)); end
            total++; if (wdata_a !== img[i]) begin bad++; $display("FAIL stream_data%0d got=%h want=%h", i, wdata_a, img[i]); end
            total++; if (cnt_a !== 9'(i + 1)) begin bad++; $display("FAIL stream_cnt%0d got=%0d want=%0d", i, cnt_a, i + 1); end
            total++; if (crst_a !== 1'b1) begin bad++; $display("FAIL stream_crst%0d got=%b want=1", i, crst_a); end
        end
        ia.ld_valid = 1'b0; ia.ld_last = 1'b0;
        total++; if (ia.ld_ready !== 1'b0) begin bad++; $display("FAIL hold_ready got=%b want=0", ia.ld_ready); end
        tick;
        total++; if (we_a !== 1'b0) begin bad++; $display("FAIL hold_we got=%b want=0", we_a); end
        total++; if (crst_a !== 1'b1) begin bad++; $display("FAIL hold_crst got=%b want=1", crst_a); end
        total++; if (done_a !== 1'b0) begin bad++; $display("FAIL hold_done got=%b want=0", done_a); end
        tick;
        total++; if (crst_a !== 1'b0) begin bad++; $display("FAIL run_crst got=%b want=0", crst_a); end
        total++; if (done_a !== 1'b1) begin bad++; $display("FAIL run_done got=%b want=1", done_a); end
        total++; if (cnt_a !== 9'd3) begin bad++; $display("FAIL run_cnt got=%0d want=3", cnt_a); end
    endtask

    task automatic test_gaps;
        reload_a = 1'b1;
        tick;
        reload_a = 1'b0;
        total++; if (crst_a !== 1'b1) begin bad++; $display("FAIL reload_crst got=%b want=1", crst_a); end
        total++; if (done_a !== 1'b0) begin bad++; $display("FAIL reload_done got=%b want=0", done_a); end
        total++; if (ia.ld_ready !== 1'b1) begin bad++; $display("FAIL reload_ready got=%b want=1", ia.ld_ready); end
        total++; if (cnt_a !== 9'd0) begin bad++; $display("FAIL reload_cnt got=%0d want=0", cnt_a); end
        for (int i = 0; i < 3; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                ia.ld_valid = 1'b0; ia.ld_data = 32'hFFFFFFFF;
                tick;
                total++; if (we_a !== 1'b0) begin bad++; $display("FAIL gap_we%0d_%0d got=%b want=0", i, g, we_a); end
            end
            ia.ld_valid = 1'b1; ia.ld_data = img[i]; ia.ld_last = (i == 2);
            tick;
            total++; if (we_a !== 1'b1) begin bad++; $display("FAIL gap_wr%0d got=%b want=1", i, we_a); end
            total++; if (waddr_a !== 10'(i * 4)) begin bad++; $display("FAIL gap_addr%0d got=%h want=%h", i, waddr_a, 10'(i * 4)); end
            total++; if (wdata_a !== img[i]) begin bad++; $display("FAIL gap_data%0d got=%h want=%h", i, wdata_a, img[i]); end
        end
        ia.ld_valid = 1'b0; ia.ld_last = 1'b0;
        tick;
        total++; if (we_a !== 1'b0) begin bad++; $display("FAIL gap_tail_we got=%b want=0", we_a); end
        tick;
        total++; if (done_a !== 1'b1) begin bad++; $display("FAIL gap_done got=%b want=1", done_a); end
        total++; if (cnt_a !== 9'd3) begin bad++; $display("FAIL gap_cnt got=%0d want=3", cnt_a); end
    endtask

    task automatic test_reload_hold;
        reload_a = 1'b1;
        tick;
        reload_a = 1'b0;
        total++; if (crst_a !== 1'b1) begin bad++; $display("FAIL rl_crst got=%b want=1", crst_a); end
        ia.ld_valid = 1'b1; ia.ld_data = 32'h0000006F; ia.ld_last = 1'b1;
        tick;
        total++; if (we_a !== 1'b1) begin bad++; $display("FAIL rl_we got=%b want=1", we_a); end
        total++; if (waddr_a !== 10'h000) begin bad++; $display("FAIL rl_addr got=%h want=000", waddr_a); end
        total++; if (wdata_a !== 32'h0000006F) begin bad++; $display("FAIL rl_data got=%h want=0000006f", wdata_a); end
        ia.ld_valid = 1'b0; ia.ld_last = 1'b0;
        reload_a = 1'b1;
        tick;
        reload_a = 1'b0;
        total++; if (ia.ld_ready !== 1'b0) begin bad++; $display("FAIL rl_hold_ready got=%b want=0", ia.ld_ready); end
        total++; if (cnt_a !== 9'd1) begin bad++; $display("FAIL rl_hold_cnt got=%0d want=1", cnt_a); end
        tick;
        total++; if (done_a !== 1'b1) begin bad++; $display("FAIL rl_done got=%b want=1", done_a); end
        total++; if (crst_a !== 1'b0) begin bad++; $display("FAIL rl_run_crst got=%b want=0", crst_a); end
        total++; if (cnt_a !== 9'd1) begin bad++; $display("FAIL rl_run_cnt got=%0d want=1", cnt_a); end
    endtask

    task automatic test_rst_midload;
        reload_a = 1'b1;
        tick;
        reload_a = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ia.ld_valid = 1'b1; ia.ld_data = 32'h11110000 + 32'(i); ia.ld_last = 1'b0;
            tick;
        end
        total++; if (cnt_a !== 9'd2) begin bad++; $display("FAIL mid_cnt got=%0d want=2", cnt_a); end
        rst_a = 1'b1; ia.ld_data = 32'hCAFEF00D;
        tick;
        total++; if (cnt_a !== 9'd0) begin bad++; $display("FAIL mid_rst_cnt got=%0d want=0", cnt_a); end
        total++; if (we_a !== 1'b0) begin bad++; $display("FAIL mid_rst_we got=%b want=0", we_a); end
        total++; if (ia.ld_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%b want=0", ia.ld_ready); end
        total++; if (waddr_a !== 10'h000) begin bad++; $display("FAIL mid_rst_addr got=%h want=000", waddr_a); end
        total++; if (wdata_a !== 32'h0) begin bad++; $display("FAIL mid_rst_data got=%h want=0", wdata_a); end
        total++; if (crst_a !== 1'b1) begin bad++; $display("FAIL mid_rst_crst got=%b want=1", crst_a); end
        rst_a = 1'b0;
        ia.ld_data = 32'h00500093; ia.ld_last = 1'b1;
        tick;
        total++; if (we_a !== 1'b1) begin bad++; $display("FAIL fresh_we got=%b want=1", we_a); end
        total++; if (waddr_a !== 10'h000) begin bad++; $display("FAIL fresh_addr got=%h want=000", waddr_a); end
        total++; if (wdata_a !== 32'h00500093) begin bad++; $display("FAIL fresh_data got=%h want=00500093", wdata_a); end
        total++; if (cnt_a !== 9'd1) begin bad++; $display("FAIL fresh_cnt got=%0d want=1", cnt_a); end
        ia.ld_valid = 1'b0; ia.ld_last = 1'b0;
        tick; tick;
        total++; if (done_a !== 1'b1) begin bad++; $display("FAIL fresh_done got=%b want=1", done_a); end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 4; i++) begin
            ib.ld_valid = 1'b1; ib.ld_data = 32'hA0 + 32'(i); ib.ld_last = 1'b0;
            tick;
            total++; if (we_b !== 1'b1) begin bad++; $display("FAIL ovf_we%0d got=%b want=1", i, we_b); end
            total++; if (waddr_b !== 10'(i * 4)) begin bad++; $display("FAIL ovf_addr%0d got=%h want=%h", i, waddr_b, 10'(i * 4)); end
            total++; if (wdata_b !== 32'hA0 + 32'(i)) begin bad++; $display("FAIL ovf_data%0d got=%h want=%h", i, wdata_b, 32'hA0 + 32'(i)); end
            total++; if (cnt_b !== 3'(i + 1)) begin bad++; $display("FAIL ovf_cnt%0d got=%0d want=%0d", i, cnt_b, i + 1); end
        end
        total++; if (err_b !== 1'b1) begin bad++; $display("FAIL ovf_err got=%b want=1", err_b); end
        total++; if (crst_b !== 1'b1) begin bad++; $display("FAIL ovf_crst got=%b want=1", crst_b); end
        total++; if (ib.ld_ready !== 1'b0) begin bad++; $display("FAIL ovf_ready got=%b want=0", ib.ld_ready); end
        total++; if (done_b !== 1'b0) begin bad++; $display("FAIL ovf_done got=%b want=0", done_b); end
        ib.ld_data = 32'hBAD0BAD0;
        tick;
        total++; if (we_b !== 1'b0) begin bad++; $display("FAIL ovf_extra_we got=%b want=0", we_b); end
        total++; if (cnt_b !== 3'd4) begin bad++; $display("FAIL ovf_sat_cnt got=%0d want=4", cnt_b); end
        total++; if (err_b !== 1'b1) begin bad++; $display("FAIL ovf_err_hold got=%b want=1", err_b); end
        ib.ld_valid = 1'b0;
        reload_b = 1'b1;
        tick;
        reload_b = 1'b0;
        total++; if (err_b !== 1'b0) begin bad++; $display("FAIL ovf_rl_err got=%b want=0", err_b); end
        total++; if (cnt_b !== 3'd0) begin bad++; $display("FAIL ovf_rl_cnt got=%0d want=0", cnt_b); end
        total++; if (ib.ld_ready !== 1'b1) begin bad++; $display("FAIL ovf_rl_ready got=%b want=1", ib.ld_ready); end
        total++; if (crst_b !== 1'b1) begin bad++; $display("FAIL ovf_rl_crst got=%b want=1", crst_b); end
    endtask

    task automatic test_last_boundary;
        for (int i = 0; i < 4; i++) begin
            ib.ld_valid = 1'b1; ib.ld_data = 32'hC0 + 32'(i); ib.ld_last = (i == 3);
            tick;
        end
        ib.ld_valid = 1'b0; ib.ld_last = 1'b0;
        total++; if (err_b !== 1'b0) begin bad++; $display("FAIL bnd_err got=%b want=0", err_b); end
        total++; if (cnt_b !== 3'd4) begin bad++; $display("FAIL bnd_cnt got=%0d want=4", cnt_b); end
        total++; if (waddr_b !== 10'h00C) begin bad++; $display("FAIL bnd_addr got=%h want=00c", waddr_b); end
        total++; if (ib.ld_ready !== 1'b0) begin bad++; $display("FAIL bnd_ready got=%b want=0", ib.ld_ready); end
        tick; tick;
        total++; if (done_b !== 1'b1) begin bad++; $display("FAIL bnd_done got=%b want=1", done_b); end
        total++; if (err_b !== 1'b0) begin bad++; $display("FAIL bnd_run_err got=%b want=0", err_b); end
        total++; if (crst_b !== 1'b0) begin bad++; $display("FAIL bnd_crst got=%b want=0", crst_b); end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; reload_a = 1'b0; reload_b = 1'b0;
        ia.ld_valid = 1'b0; ia.ld_data = '0; ia.ld_last = 1'b0;
        ib.ld_valid = 1'b0; ib.ld_data = '0; ib.ld_last = 1'b0;
        test_reset;
        test_stream;
        test_gaps;
        test_reload_hold;
        test_rst_midload;
        test_overflow;
        test_last_boundary;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
